nsum_gen: RTL and testbench

- Parametrised successor to the team's fixed 3-bit / 8-bit N-sum datapath-plus-controller block.
- Accepts an unsigned N and a mode, then iteratively computes one of:
  - mode 0: the triangular sum 1+2+…+N.
  - mode 1: the sum of squares 1²+2²+…+N², formed by nested repeated addition.
- Single-request handshake with a busy indicator; the result is held stable between requests.
- Sits as a standalone compute unit beside the lab datapath blocks; one datapath and one FSM in a single module.

---
 rtl/nsum_gen.sv | 140 ++++++++++++++
 tb/tb_nsum_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nsum_gen.sv
// nsum_gen: iterative triangular / sum-of-squares generator, one datapath + FSM.
// Optional carry-out flag on output ovf when NSUM_OVF_EN is defined.
module nsum_gen #(
  parameter int N_W   = 3,
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_W-1:0]   N,
  input  logic             mode,
  input  logic             N_valid,
  output logic             busy,
  output logic             sum_valid,
`ifdef NSUM_OVF_EN
  output logic             ovf,
`endif
  output logic [SUM_W-1:0] sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_W-1:0]   i_q;
  logic [N_W-1:0]   j_q;
  logic [SUM_W-1:0] acc_q;
  logic             mode_q;
  logic             busy_q;
  logic             sv_q;
  logic [SUM_W-1:0] sum_q;

  logic [SUM_W-1:0] acc_d;
  logic             last_add;

`ifdef NSUM_OVF_EN
  logic             ovf_flag_q;
  logic             ovf_q;
  logic [SUM_W:0]   add_w;
  logic             carry;

  assign add_w = {1'b0, acc_q} + (SUM_W+1)'(i_q);
  assign acc_d = add_w[SUM_W-1:0];
  assign carry = add_w[SUM_W];
  assign ovf   = ovf_q;
`else
  assign acc_d = acc_q + SUM_W'(i_q);
`endif

  // The add this RUN cycle is the final one of the request.
  always_comb begin
    last_add = 1'b0;
    if (mode_q == 1'b0) begin
      last_add = (i_q == N_W'(1));
    end else begin
      last_add = (j_q == i_q) && (i_q == N_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      sv_q       <= 1'b0;
      sum_q      <= '0;
`ifdef NSUM_OVF_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          sv_q <= 1'b0;
          if (N_valid) begin
            i_q        <= N;
            j_q        <= N_W'(1);
            acc_q      <= '0;
            mode_q     <= mode;
            busy_q     <= 1'b1;
`ifdef NSUM_OVF_EN
            ovf_flag_q <= 1'b0;
`endif
            if (N == '0) begin
              state_q <= DONE;
              sum_q   <= '0;
              sv_q    <= 1'b1;
`ifdef NSUM_OVF_EN
              ovf_q   <= 1'b0;
`endif
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
`ifdef NSUM_OVF_EN
          ovf_flag_q <= ovf_flag_q | carry;
`endif
          if (last_add) begin
            state_q <= DONE;
            sum_q   <= acc_d;
            sv_q    <= 1'b1;
`ifdef NSUM_OVF_EN
            ovf_q   <= ovf_flag_q | carry;
`endif
          end else if (mode_q == 1'b0) begin
            i_q <= i_q - N_W'(1);
          end else if (j_q == i_q) begin
            i_q <= i_q - N_W'(1);
            j_q <= N_W'(1);
          end else begin
            j_q <= j_q + N_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sv_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sum_valid = sv_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_nsum_gen.sv
// tb_nsum_gen: directed + random requests checked cycle by cycle
// against an arithmetic model of the N-sum rules.
module tb_nsum_gen;

  localparam int N_W   = 4;
  localparam int SUM_W = 8;
  localparam int MODV  = 1 << SUM_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_W-1:0]   N = '0;
  logic             mode = 1'b0;
  logic             N_valid = 1'b0;
  logic             busy;
  logic             sum_valid;
  logic [SUM_W-1:0] sum;
`ifdef NSUM_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int failures = 0;
  int prev_sum = 0;
  int prev_ovf = 0;

  nsum_gen #(.N_W(N_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .N         (N),
    .mode      (mode),
    .N_valid   (N_valid),
    .busy      (busy),
    .sum_valid (sum_valid),
`ifdef NSUM_OVF_EN
    .ovf       (ovf),
`endif
    .sum       (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Plain arithmetic reference: sum of k or k*k, wrap and sticky carry.
  task automatic ref_model(input int n, input int m, output int s,
                           output int o, output int lat);
    int acc;
    acc = 0;
    o = 0;
    for (int k = 1; k <= n; k++) begin
      acc = acc + (m ? k * k : k);
      if (acc >= MODV) o = 1;
      acc = acc % MODV;
    end
    s = acc;
    if (n == 0) lat = 1;
    else if (m == 0) lat = n + 1;
    else lat = n * (n + 1) / 2 + 1;
  endtask

  task automatic check_outs(input int c, input int lat, input int es,
                            input int eo);
    chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= lat));
    chk($sformatf("sv c%0d", c), 32'(sum_valid), 32'(c == lat));
    chk($sformatf("sum c%0d", c), 32'(sum), (c >= lat) ? es : prev_sum);
`ifdef NSUM_OVF_EN
    chk($sformatf("ovf c%0d", c), 32'(ovf), (c >= lat) ? eo : prev_ovf);
`else
    if (eo < 0) $display("unreachable");
`endif
  endtask

  task automatic run_req(input int n, input int m, input bit junk);
    int es, eo, lat;
    ref_model(n, m, es, eo, lat);
    @(negedge clk);
    N = N_W'(n);
    mode = m[0];
    N_valid = 1'b1;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      check_outs(c, lat, es, eo);
      if (junk && c <= lat) begin
        N = N_W'($urandom);
        mode = 1'($urandom);
        N_valid = 1'b1;
      end else begin
        N_valid = 1'b0;
      end
    end
    prev_sum = es;
    prev_ovf = eo;
  endtask

  initial begin
    #12;
    chk("rst busy", 32'(busy), 0);
    chk("rst sv", 32'(sum_valid), 0);
    chk("rst sum", 32'(sum), 0);
    @(negedge clk);
    reset = 1'b0;

    run_req(5, 0, 0);
    run_req(7, 1, 0);
    run_req(3, 0, 0);
    run_req(0, 0, 0);
    run_req(0, 1, 0);
    run_req(4, 1, 1);

    // Async reset in the middle of a sum-of-squares request.
    @(negedge clk);
    N = 4'd6;
    mode = 1'b1;
    N_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      N_valid = 1'b0;
      chk($sformatf("pre-rst busy c%0d", c), 32'(busy), 1);
    end
    #2 reset = 1'b1;
    #1;
    chk("async busy", 32'(busy), 0);
    chk("async sv", 32'(sum_valid), 0);
    chk("async sum", 32'(sum), 0);
`ifdef NSUM_OVF_EN
    chk("async ovf", 32'(ovf), 0);
`endif
    prev_sum = 0;
    prev_ovf = 0;
    @(posedge clk);
    #1 chk("held busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    run_req(2, 0, 0);

    run_req(15, 1, 0);
    run_req(5, 0, 0);
    run_req(15, 0, 1);

    for (int r = 0; r < 20; r++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        N = N_W'($urandom);
        mode = 1'($urandom);
        chk("idle busy", 32'(busy), 0);
        chk("idle sum", 32'(sum), prev_sum);
      end
      run_req(int'($urandom_range(0, (1 << N_W) - 1)),
              int'($urandom_range(0, 1)), bit'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
